// File: rtl/blake2_ctrl_pkg.sv
// Blake2 block sequencer shared types:
// FSM state encoding and Blake2 core operand widths.
package blake2_ctrl_pkg;

  localparam int BLOCK_W  = 1024;
  localparam int LEN_W    = 128;
  localparam int DIGEST_W = 512;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_INIT,
    FILL,
    ISSUE,
    WAIT_CORE,
    WAIT_DIGEST
  } state_t;

endpackage

// File: rtl/blake2_block_sequencer_if.sv
// Message word stream into the Blake2 block sequencer.
// master drives words, slave accepts them with s_ready.
interface blake2_block_sequencer_if #(
  parameter int WORD_W = 32
);

  localparam int LB_W = $clog2(WORD_W/8) + 1;

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;
  logic [LB_W-1:0]   s_last_bytes;

  modport master (
    output s_valid, s_data, s_last, s_last_bytes,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, s_last, s_last_bytes,
    output s_ready
  );

endinterface

// File: rtl/blake2_block_packer.sv
// Packs little-endian message words into the 1024-bit block
// buffer, masking unused bytes of the last word.
module blake2_block_packer
  import blake2_ctrl_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LB_W   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               wr,
  input  logic               last,
  input  logic [WORD_W-1:0]  data,
  input  logic [LB_W-1:0]    last_bytes,
  output logic [BLOCK_W-1:0] block,
  output logic               full
);

  localparam int NW    = BLOCK_W / WORD_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] wword;

  assign full = (idx == IDX_W'(NW - 1));

  always_comb begin
    wword = '0;
    for (int b = 0; b < WORD_W/8; b++) begin
      if (!last || (LB_W'(b) < last_bytes))
        wword[b*8 +: 8] = data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      block <= '0;
    end else if (clr) begin
      idx   <= '0;
      block <= '0;
    end else if (wr) begin
      block[int'(idx)*WORD_W +: WORD_W] <= wword;
      idx <= full ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/blake2_block_sequencer.sv
// Feeds a Blake2 core with 1024-bit blocks built from a word stream.
// Define BLAKE2_SEQ_BLKCNT_EN to add the blk_count output.
module blake2_block_sequencer
  import blake2_ctrl_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               msg_start,
  blake2_block_sequencer_if.slave s,
  output logic               init,
  output logic               next,
  output logic               final_block,
  output logic [BLOCK_W-1:0] block,
  output logic [LEN_W-1:0]   data_length,
  input  logic               hash_ready,
  input  logic               digest_valid,
  output logic               busy
`ifdef BLAKE2_SEQ_BLKCNT_EN
  ,
  output logic [31:0]        blk_count
`endif
);

  localparam int LB_W = $clog2(WORD_W/8) + 1;

  state_t state, state_n;
  logic   acc;
  logic   full;
  logic   clr;

  assign s.s_ready = (state == FILL);
  assign busy      = (state != IDLE);
  assign acc       = s.s_valid && (state == FILL);
  // Keep the issued block visible until the core takes it.
  assign clr       = (state == IDLE) ||
                     ((state == WAIT_CORE) && hash_ready);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:        if (msg_start) state_n = INIT;
      INIT:        state_n = WAIT_INIT;
      WAIT_INIT:   if (hash_ready) state_n = FILL;
      FILL:        if (acc && (s.s_last || full)) state_n = ISSUE;
      ISSUE:       state_n = final_block ? WAIT_DIGEST : WAIT_CORE;
      WAIT_CORE:   if (hash_ready) state_n = FILL;
      WAIT_DIGEST: if (digest_valid) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      init        <= 1'b0;
      next        <= 1'b0;
      final_block <= 1'b0;
    end else begin
      state       <= state_n;
      init        <= (state_n == INIT);
      next        <= (state_n == ISSUE);
      final_block <= (state_n == ISSUE) && s.s_last;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      data_length <= '0;
    else if (state == IDLE)
      data_length <= '0;
    else if (acc)
      data_length <= data_length +
        (s.s_last ? LEN_W'(s.s_last_bytes) : LEN_W'(WORD_W/8));
  end

`ifdef BLAKE2_SEQ_BLKCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      blk_count <= '0;
    else if ((state == IDLE) && msg_start)
      blk_count <= '0;
    else if ((state_n == ISSUE) && (blk_count != '1))
      blk_count <= blk_count + 1'b1;
  end
`endif

  blake2_block_packer #(
    .WORD_W (WORD_W),
    .LB_W   (LB_W)
  ) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .wr         (acc),
    .last       (s.s_last),
    .data       (s.s_data),
    .last_bytes (s.s_last_bytes),
    .block      (block),
    .full       (full)
  );

endmodule

// File: tb/tb_blake2_block_sequencer.sv
// Directed bench for blake2_block_sequencer with a Blake2 core model
// and a scoreboard of expected next-pulse operands.
module tb_blake2_block_sequencer;

  typedef struct packed {
    logic         fin;
    logic [127:0] len;
    logic [1023:0] blk;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic msg_start;
  logic init, next, final_block, busy;
  logic [1023:0] block;
  logic [127:0]  data_length;
  logic hash_ready, digest_valid;
`ifdef BLAKE2_SEQ_BLKCNT_EN
  logic [31:0] blk_count;
`endif

  int checks = 0;
  int failures = 0;
  int n_init = 0;
  int n_next = 0;
  int core_lat = 3;
  int cnt = 0;
  bit fin = 1'b0;
  exp_t exp_q[$];
  exp_t cur;

  always #5 clk = ~clk;

  blake2_block_sequencer_if #(.WORD_W(32)) sif ();

  blake2_block_sequencer #(.WORD_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .msg_start    (msg_start),
    .s            (sif),
    .init         (init),
    .next         (next),
    .final_block  (final_block),
    .block        (block),
    .data_length  (data_length),
    .hash_ready   (hash_ready),
    .digest_valid (digest_valid),
    .busy         (busy)
`ifdef BLAKE2_SEQ_BLKCNT_EN
    ,
    .blk_count    (blk_count)
`endif
  );

  task automatic chk(input string tag,
                     input logic [1023:0] obs,
                     input logic [1023:0] expv);
    int d;
    checks++;
    assert (obs === expv) else begin
      failures++;
      d = 0;
      for (int i = 31; i >= 0; i--)
        if (obs[i*32 +: 32] !== expv[i*32 +: 32]) d = i;
      $error("FAIL %s word%0d observed=%h expected=%h",
             tag, d, obs[d*32 +: 32], expv[d*32 +: 32]);
    end
  endtask

  // Core model: busy for core_lat cycles after each command.
  always @(negedge clk) begin
    if (!reset_n) begin
      hash_ready   = 1'b1;
      digest_valid = 1'b0;
      cnt = 0;
      fin = 1'b0;
    end else begin
      digest_valid = 1'b0;
      if (init || next) begin
        hash_ready = 1'b0;
        cnt = core_lat;
        fin = final_block;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          hash_ready   = 1'b1;
          digest_valid = fin;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (init) n_init++;
      if (next) begin
        n_next++;
        if (exp_q.size() == 0) begin
          chk("next_expected", 1024'(exp_q.size()), 1024'd1);
        end else begin
          cur = exp_q.pop_front();
          chk("final_block", 1024'(final_block), 1024'(cur.fin));
          chk("data_length", 1024'(data_length), 1024'(cur.len));
          chk("block", block, cur.blk);
        end
      end
    end
  end

  task automatic start_msg();
    @(negedge clk);
    msg_start = 1'b1;
    @(negedge clk);
    msg_start = 1'b0;
  endtask

  task automatic send_msg(input int nw, input int lb,
                          input logic [31:0] w0, input bit with_last);
    exp_t e;
    int k;
    int t;
    logic [31:0] w, wm;
    bit lst;
    e = '0;
    k = 0;
    for (int i = 0; i < nw; i++) begin
      w = (i == 0) ? w0 : $urandom;
      lst = with_last && (i == nw - 1);
      wm = w;
      if (lst)
        for (int b = lb; b < 4; b++) wm[b*8 +: 8] = 8'h00;
      e.blk[k*32 +: 32] = wm;
      e.len += lst ? 128'(lb) : 128'd4;
      k++;
      if (k == 32 || lst) begin
        e.fin = lst;
        exp_q.push_back(e);
        e.blk = '0;
        k = 0;
      end
      @(negedge clk);
      sif.s_valid      = 1'b1;
      sif.s_data       = w;
      sif.s_last       = lst;
      sif.s_last_bytes = 3'(lb);
      t = 0;
      while (!sif.s_ready && t < 500) begin
        @(negedge clk);
        t++;
      end
      chk("accept_in_time", 1024'(t < 500), 1024'd1);
    end
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("idle_in_time", 1024'(t < 500), 1024'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, n0;
    reset_n = 1'b0;
    msg_start = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    sif.s_last = 1'b0;
    sif.s_last_bytes = '0;
    repeat (3) @(negedge clk);
    chk("rst_init", 1024'(init), 1024'd0);
    chk("rst_next", 1024'(next), 1024'd0);
    chk("rst_final", 1024'(final_block), 1024'd0);
    chk("rst_s_ready", 1024'(sif.s_ready), 1024'd0);
    chk("rst_busy", 1024'(busy), 1024'd0);
    chk("rst_block", block, 1024'd0);
    chk("rst_len", 1024'(data_length), 1024'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 1024'(busy), 1024'd0);

    // single partial word, final
    i0 = n_init; n0 = n_next;
    start_msg();
    send_msg(1, 3, 32'h11223344, 1);
    wait_idle();
    chk("a_init_cnt", 1024'(n_init - i0), 1024'd1);
    chk("a_next_cnt", 1024'(n_next - n0), 1024'd1);

    // 33 words: full block then one-word final block
    n0 = n_next;
    start_msg();
    send_msg(33, 4, 32'hDEADBEEF, 1);
    wait_idle();
    chk("b_next_cnt", 1024'(n_next - n0), 1024'd2);
`ifdef BLAKE2_SEQ_BLKCNT_EN
    chk("b_blk_count", 1024'(blk_count), 1024'd2);
`endif

    // exactly 32 words, last on word 31
    n0 = n_next;
    @(negedge clk);
    msg_start = 1'b1;
    @(negedge clk);
    msg_start = 1'b0;
    chk("c_init_pulse", 1024'(init), 1024'd1);
`ifdef BLAKE2_SEQ_BLKCNT_EN
    chk("c_blk_count_clr", 1024'(blk_count), 1024'd0);
`endif
    send_msg(32, 4, 32'hCAFEF00D, 1);
    wait_idle();
    chk("c_next_cnt", 1024'(n_next - n0), 1024'd1);

    // core stalls for more than 10 cycles after a non-final block
    core_lat = 12;
    start_msg();
    fork
      send_msg(33, 1, 32'h0BADF00D, 1);
      begin : watch
        int t;
        logic [1023:0] saved;
        t = 0;
        while (!next && t < 300) begin
          @(negedge clk);
          t++;
        end
        chk("d_next_seen", 1024'(t < 300), 1024'd1);
        saved = block;
        repeat (10) begin
          @(negedge clk);
          #1;
          chk("d_s_ready", 1024'(sif.s_ready), 1024'd0);
          chk("d_no_pulse", 1024'(init | next), 1024'd0);
          chk("d_block", block, saved);
        end
        t = 0;
        while (!hash_ready && t < 50) begin
          @(negedge clk);
          #1;
          t++;
        end
        chk("d_release", 1024'(t < 50), 1024'd1);
        @(negedge clk);
        chk("d_resume", 1024'(sif.s_ready), 1024'd1);
      end
    join
    wait_idle();
    core_lat = 3;

    // msg_start ignored mid-FILL, then reset mid-FILL
    start_msg();
    send_msg(5, 4, 32'h01020304, 0);
    chk("e_len_mid", 1024'(data_length), 1024'd20);
    i0 = n_init;
    start_msg();
    repeat (3) @(negedge clk);
    chk("e_no_init", 1024'(n_init - i0), 1024'd0);
    chk("e_still_fill", 1024'(sif.s_ready), 1024'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("e_rst_init", 1024'(init), 1024'd0);
    chk("e_rst_next", 1024'(next), 1024'd0);
    chk("e_rst_final", 1024'(final_block), 1024'd0);
    chk("e_rst_s_ready", 1024'(sif.s_ready), 1024'd0);
    chk("e_rst_busy", 1024'(busy), 1024'd0);
    chk("e_rst_block", block, 1024'd0);
    chk("e_rst_len", 1024'(data_length), 1024'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    i0 = n_init;
    start_msg();
    send_msg(1, 2, 32'hA5A5A5A5, 1);
    wait_idle();
    chk("e_fresh_init", 1024'(n_init - i0), 1024'd1);
    chk("queue_drained", 1024'(exp_q.size()), 1024'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blake2_block_sequencer.md
BLAKE2_BLOCK_SEQUENCER -- requirements
Module: blake2_block_sequencer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, the input word width in bits; it is a multiple of 8 and divides 1024.
REQ-002 SHALL have ports clk (in, 1, the only clock) and reset_n (in, 1). Reset is asynchronous and active-low.
REQ-003 SHALL have msg_start (in, 1), a new-hash request.
REQ-004 SHALL have s_valid (in, 1, input word valid), s_data (in, WORD_W, input word) and s_ready (out, 1, word accepted when s_valid&&s_ready).
REQ-005 SHALL have s_last (in, 1, final word of the message) and s_last_bytes (in, $clog2(WORD_W/8)+1, valid bytes in the final word, range 1..WORD_W/8).
REQ-006 SHALL have init, next and final_block (out, 1 each), the Blake2 core commands.
REQ-007 SHALL have block (out, 1024) and data_length (out, 128), the Blake2 core operands.
REQ-008 SHALL have hash_ready (in, 1) and digest_valid (in, 1), the Blake2 core status.
REQ-009 SHALL have busy (out, 1), high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL implement the states IDLE, INIT, WAIT_INIT, FILL, ISSUE, WAIT_CORE and WAIT_DIGEST.
REQ-011 IDLE: msg_start=1 SHALL go to INIT. msg_start SHALL be ignored in every other state.
REQ-012 INIT: SHALL drive init=1 for exactly one cycle, then go to WAIT_INIT. WAIT_INIT: SHALL go to FILL on the first cycle hash_ready=1.
REQ-013 FILL: s_ready SHALL be 1. Every other state SHALL hold s_ready=0.
REQ-014 Packing: the word with index k (0..1024/WORD_W-1) SHALL be placed at block[k*WORD_W +: WORD_W], little-endian bytes.
REQ-015 Unused bytes of the last word and all unwritten words SHALL read 0 in block. The buffer SHALL be cleared after every ISSUE.
REQ-016 data_length SHALL accumulate WORD_W/8 per accepted non-last word and s_last_bytes for the last word. It wraps modulo 2^128.
REQ-017 Transition out of FILL: an accepted word that fills the block, or any accepted word with s_last=1, SHALL go to ISSUE on the next cycle.
REQ-018 ISSUE: SHALL drive next=1 for one cycle. final_block SHALL be 1 in that cycle if and only if the block contains the s_last word. block and data_length SHALL be stable from ISSUE until hash_ready next rises.
REQ-019 A full block whose final word has s_last=1 SHALL be one final block. No empty extra block SHALL be issued.
REQ-020 After ISSUE: a non-final block SHALL go to WAIT_CORE, which returns to FILL on hash_ready=1. A final block SHALL go to WAIT_DIGEST, which returns to IDLE on digest_valid=1.
REQ-021 In IDLE, data_length and the word index SHALL be cleared to 0.
REQ-022 init, next and final_block SHALL be registered, single-cycle pulses and mutually exclusive with init.

Reset
REQ-023 reset_n=0 SHALL force IDLE and clear to 0: init, next, final_block, s_ready, busy, block, data_length, the word index and the block counter. This applies in any state, including mid-FILL and mid-WAIT.
REQ-024 The first cycle after reset release SHALL behave as IDLE.

Configuration
REQ-025 With macro BLAKE2_SEQ_BLKCNT_EN defined, the block SHALL add output blk_count (out, 32). It counts next pulses in the current message, clears on entering INIT and saturates at 0xFFFFFFFF.
REQ-026 Without BLAKE2_SEQ_BLKCNT_EN, the blk_count port and its logic SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-027 Package blake2_ctrl_pkg SHALL hold the FSM state enum and the constants BLOCK_W=1024, LEN_W=128 and DIGEST_W=512.
REQ-028 Sub-module blake2_block_packer SHALL contain the word index, the byte-masked write into the 1024-bit buffer and the clear. The top level SHALL contain the FSM and the length counter.

Verification
REQ-029 WORD_W=32, one word 0x11223344 with s_last=1 and s_last_bytes=3 -> one init pulse and one next pulse with final_block=1, block[31:0]=0x00223344, the rest 0, data_length=3.
REQ-030 32 words without s_last, then one word with s_last=1 and s_last_bytes=4 -> 1st next has final_block=0 and data_length=128. 2nd next has final_block=1, data_length=132 and block[1023:32]=0.
REQ-031 Exactly 32 words with s_last on word 31 -> exactly one next pulse, with final_block=1 and data_length=128.
REQ-032 hash_ready held 0 for 10 cycles after a non-final next -> s_ready=0 throughout, no further pulse, block unchanged. FILL resumes 1 cycle after hash_ready=1.
REQ-033 msg_start pulsed while in FILL -> no init pulse. reset_n=0 mid-FILL -> IDLE, all outputs 0, and a fresh msg_start then produces init.
REQ-034 With BLAKE2_SEQ_BLKCNT_EN, the REQ-030 stimulus -> blk_count=2 after the final next, and 0 after the next init.
